// File: rtl/picosoc_bus_fabric_pkg.sv
// ============================================================================
// picosoc_bus_pkg: FSM states, error codes and helpers for picosoc_bus_fabric
// Revision: 1.0
// ============================================================================
`default_nettype none

package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0]  ERR_NONE         = 2'b00;
  localparam logic [1:0]  ERR_UNMAPPED     = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT      = 2'b10;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/picosoc_bus_fabric_if.sv
// ============================================================================
// picosoc_bus_fabric_if: CPU native bus plus broadcast peripheral channels
// Revision: 1.0
// ============================================================================
`default_nettype none

interface picosoc_bus_fabric_if #(
  parameter int NUM_SLAVES = 4
);
  logic                     mem_valid;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_ready;
  logic [31:0]              mem_rdata;
  logic [NUM_SLAVES-1:0]    s_valid;
  logic [31:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [3:0]               s_wstrb;
  logic [NUM_SLAVES-1:0]    s_ready;
  logic [NUM_SLAVES*32-1:0] s_rdata;

  // Fabric side: target of the CPU, initiator toward the peripherals
  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, s_ready, s_rdata,
    output mem_ready, mem_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, s_ready, s_rdata,
    input  mem_ready, mem_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

`default_nettype wire

// File: rtl/picosoc_bus_fabric_addr_decode.sv
// ============================================================================
// bus_addr_decode: combinational base/mask matcher, lowest index wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_addr_decode
  import picosoc_bus_pkg::*;
#(
  parameter int                      NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
    {32'h0400_0000, 32'h0301_0000, 32'h0300_0000, 32'h0200_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
    {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00},
  localparam int                     SEL_W = sel_width(NUM_SLAVES)
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [SEL_W-1:0] sel_o
);

  // Scan downward so the last (lowest) matching index is the one kept
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit_o = 1'b1;
        sel_o = SEL_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/picosoc_bus_fabric.sv
// ============================================================================
// picosoc_bus_fabric: registered N-slave decoder/response mux with timeout
// and sticky error capture. Optional counters: BUS_TXN_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module picosoc_bus_fabric
  import picosoc_bus_pkg::*;
#(
  parameter int                      NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     =
    {32'h0400_0000, 32'h0301_0000, 32'h0300_0000, 32'h0200_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     =
    {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00},
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_DATA       = DEFAULT_ERR_DATA,
  parameter int                      CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  picosoc_bus_fabric_if.slave         bus,
  input  logic                        err_clr,
  output logic                        err_flag,
  output logic [1:0]                  err_code,
  output logic [31:0]                 err_addr,
  output logic [NUM_SLAVES*CNT_W-1:0] txn_count
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                state_q;
  logic [SEL_W-1:0]      sel_q;
  logic [TO_W-1:0]       tmo_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [NUM_SLAVES-1:0] s_valid_q;
  logic                  mem_ready_q;
  logic [31:0]           mem_rdata_q;
  logic                  err_flag_q;
  logic [1:0]            err_code_q;
  logic [31:0]           err_addr_q;

  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_sel;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  tmo_expired;
  logic [1:0]            err_new_code;
  logic [31:0]           err_new_addr;

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr_i (bus.mem_addr),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel)
  );

  always_comb begin
    dec_onehot          = '0;
    dec_onehot[dec_sel] = 1'b1;
  end

  assign sel_ready   = bus.s_ready[sel_q];
  assign sel_rdata   = bus.s_rdata[sel_q*32 +: 32];
  assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_q == TO_LAST);

  always_comb begin
    err_new_code = ERR_NONE;
    err_new_addr = '0;
    if (state_q == ST_IDLE && bus.mem_valid && !dec_hit) begin
      err_new_code = ERR_UNMAPPED;
      err_new_addr = bus.mem_addr;
    end else if (state_q == ST_ACTIVE && !sel_ready && tmo_expired) begin
      err_new_code = ERR_TIMEOUT;
      err_new_addr = addr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      s_valid_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_valid) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            tmo_q   <= '0;
            if (dec_hit) begin
              sel_q     <= dec_sel;
              s_valid_q <= dec_onehot;
              state_q   <= ST_ACTIVE;
            end else begin
              mem_ready_q <= 1'b1;
              mem_rdata_q <= ERR_DATA;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_ACTIVE: begin
          // A ready arriving on the last allowed cycle still wins over the timeout
          if (sel_ready) begin
            s_valid_q   <= '0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= sel_rdata;
            state_q     <= ST_RESP;
          end else if (tmo_expired) begin
            s_valid_q   <= '0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= ERR_DATA;
            state_q     <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flag_q <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else if (err_new_code != ERR_NONE && (!err_flag_q || err_clr)) begin
      err_flag_q <= 1'b1;
      err_code_q <= err_new_code;
      err_addr_q <= err_new_addr;
    end else if (err_clr) begin
      err_flag_q <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end
  end

`ifdef BUS_TXN_COUNT_EN
  logic [NUM_SLAVES*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (state_q == ST_ACTIVE && sel_ready) begin
      cnt_q[sel_q*CNT_W +: CNT_W] <= cnt_q[sel_q*CNT_W +: CNT_W] + 1'b1;
    end
  end

  assign txn_count = cnt_q;
`else
  assign txn_count = '0;
`endif

  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.s_valid   = s_valid_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.s_wstrb   = wstrb_q;
  assign err_flag      = err_flag_q;
  assign err_code      = err_code_q;
  assign err_addr      = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_picosoc_bus_fabric.sv
// ============================================================================
// tb_picosoc_bus_fabric: directed bench with a transaction-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_picosoc_bus_fabric;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        err_clr;
  logic        err_flag;
  logic [1:0]  err_code;
  logic [31:0] err_addr;
  logic [63:0] txn_count;

  picosoc_bus_fabric_if #(.NUM_SLAVES(4)) bus ();

  picosoc_bus_fabric #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_code  (err_code),
    .err_addr  (err_addr),
    .txn_count (txn_count)
  );

  initial forever #5 clk = ~clk;

  // Memory map and slave behaviour, indexed by slave number
  logic [31:0] m_base [4] = '{32'h0200_0000, 32'h0300_0000, 32'h0301_0000, 32'h0400_0000};
  logic [31:0] m_mask [4] = '{32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000};
  logic [31:0] sdata  [4] = '{32'hC0DE_0000, 32'h1234_5678, 32'h5A5A_2222, 32'h3333_3333};
  int          wait_cfg [4] = '{0, 0, 0, 0};
  bit  [3:0]   noise = '0;
  int          vcnt [4] = '{0, 0, 0, 0};

  // Expected outputs
  bit          chk_en = 1'b0;
  logic [3:0]  e_sv = '0;
  bit          e_ready = 1'b0;
  logic [31:0] e_rdata = '0, e_saddr = '0, e_swdata = '0;
  logic [3:0]  e_swstrb = '0;
  bit          e_eflag = 1'b0;
  logic [1:0]  e_ecode = '0;
  logic [31:0] e_eaddr = '0;
  logic [15:0] e_cnt [4] = '{16'd0, 16'd0, 16'd0, 16'd0};

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, ready_cyc = 0, sv_cnt = 0, pulses = 0;
  int sv0 = 0, p0 = 0;
  logic [31:0] rd_obs = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_decode(input logic [31:0] a, output bit hit, output int sel);
    hit = 1'b0;
    sel = 0;
    for (int i = 0; i < 4; i++)
      if (!hit && ((a & m_mask[i]) == m_base[i])) begin
        hit = 1'b1;
        sel = i;
      end
  endfunction

  function automatic void m_err(input logic [1:0] code, input logic [31:0] a);
    if (!e_eflag) begin
      e_eflag = 1'b1;
      e_ecode = code;
      e_eaddr = a;
    end
  endfunction

  function automatic void m_clear();
    e_eflag = 1'b0;
    e_ecode = '0;
    e_eaddr = '0;
`ifdef BUS_TXN_COUNT_EN
    for (int i = 0; i < 4; i++) e_cnt[i] = '0;
`endif
  endfunction

  initial forever @(posedge clk) cyc++;

  // Peripheral responders: ready after wait_cfg cycles of s_valid, plus optional noise
  initial begin
    bus.s_ready = '0;
    bus.s_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (bus.s_valid[i]) begin
          bus.s_ready[i] = noise[i] | (vcnt[i] >= wait_cfg[i]);
          vcnt[i]++;
        end else begin
          bus.s_ready[i] = noise[i];
          vcnt[i] = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("mem_ready", bus.mem_ready, e_ready);
      check("mem_rdata", bus.mem_rdata, e_rdata);
      check("s_valid",   bus.s_valid,   e_sv);
      check("s_addr",    bus.s_addr,    e_saddr);
      check("s_wdata",   bus.s_wdata,   e_swdata);
      check("s_wstrb",   bus.s_wstrb,   e_swstrb);
      check("err_flag",  err_flag,      e_eflag);
      check("err_code",  err_code,      e_ecode);
      check("err_addr",  err_addr,      e_eaddr);
      check("txn_count", txn_count,     {e_cnt[3], e_cnt[2], e_cnt[1], e_cnt[0]});
      if (bus.s_valid != '0) sv_cnt++;
      if (bus.mem_ready) begin
        ready_cyc = cyc;
        rd_obs    = bus.mem_rdata;
        pulses++;
      end
    end
  end

  // One CPU transaction; expectations follow the latency rules, entered #1 after an edge
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input bit hold, input bit clr);
    bit hit;
    int sel;
    int act;
    bit tmo;
    m_decode(a, hit, sel);
    sv0 = sv_cnt;
    p0  = pulses;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    err_clr       = clr;
    @(posedge clk); #1;
    acc_cyc = cyc;
    err_clr = 1'b0;
    if (!hold) begin
      bus.mem_valid = 1'b0;
      bus.mem_addr  = ~a;
      bus.mem_wdata = ~wd;
      bus.mem_wstrb = ~ws;
    end
    e_saddr  = a;
    e_swdata = wd;
    e_swstrb = ws;
    if (clr) m_clear();
    if (hit) begin
      tmo = (wait_cfg[sel] >= TMO);
      act = tmo ? TMO : wait_cfg[sel] + 1;
      e_sv = '0;
      e_sv[sel] = 1'b1;
      repeat (act) begin @(posedge clk); #1; end
      bus.mem_valid = 1'b0;
      e_sv    = '0;
      e_ready = 1'b1;
      if (tmo) begin
        e_rdata = ERR;
        m_err(2'b10, a);
      end else begin
        e_rdata = sdata[sel];
`ifdef BUS_TXN_COUNT_EN
        e_cnt[sel]++;
`endif
      end
    end else begin
      bus.mem_valid = 1'b0;
      e_ready = 1'b1;
      e_rdata = ERR;
      m_err(2'b01, a);
    end
    @(posedge clk); #1;
    e_ready = 1'b0;
    e_rdata = '0;
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_clear();
  endtask

  initial begin
    resetn        = 1'b0;
    err_clr       = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_ready", bus.mem_ready, 0);
    check("rst_s_valid",   bus.s_valid,   0);
    check("rst_err_flag",  err_flag,      0);
    resetn = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read on slave1
    txn(32'h0300_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    check("t1_latency", ready_cyc - acc_cyc + 1, 2);
    check("t1_rdata",   rd_obs, 32'h1234_5678);
    check("t1_sv_cyc",  sv_cnt - sv0, 1);
    check("t1_err",     err_flag, 0);

    // Write to slave2 with 5 wait cycles, CPU holds valid, then back-to-back read of slave0
    wait_cfg[2] = 5;
    txn(32'h0301_0004, 32'hA5A5_0001, 4'hF, 1'b1, 1'b0);
    check("t2_pulses", pulses - p0, 1);
    check("t2_sv_cyc", sv_cnt - sv0, 6);
    txn(32'h0200_0004, 32'h0, 4'h0, 1'b0, 1'b0);
    check("t3_b2b_latency", ready_cyc - acc_cyc + 1, 2);
    check("t3_rdata", rd_obs, 32'hC0DE_0000);

    // Unmapped read, then unmapped write must not overwrite the first error
    txn(32'h0500_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    check("t4_latency", ready_cyc - acc_cyc + 1, 1);
    check("t4_rdata",   rd_obs, 32'hDEAD_BEEF);
    check("t4_code",    err_code, 2'b01);
    check("t4_addr",    err_addr, 32'h0500_0000);
    txn(32'h0600_0000, 32'h1111_2222, 4'hF, 1'b0, 1'b0);
    check("t5_addr_sticky", err_addr, 32'h0500_0000);
    do_clr();
    check("t5_clr_flag", err_flag, 0);

    // Three slave1 accesses, then a timeout on slave3 with ready noise on others
    repeat (2) txn(32'h0300_0100, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(32'h0300_FFFC, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_cfg[3] = 100;
    noise = 4'b0011;
    txn(32'h0400_0040, 32'h0, 4'h0, 1'b0, 1'b0);
    noise = 4'b0000;
    check("t6_sv_cyc", sv_cnt - sv0, 8);
    check("t6_rdata",  rd_obs, 32'hDEAD_BEEF);
    check("t6_code",   err_code, 2'b10);
`ifdef BUS_TXN_COUNT_EN
    check("t6_cnt1", txn_count[31:16], 16'd3);
    check("t6_cnt3", txn_count[63:48], 16'd0);
`endif
    txn(32'h0200_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    check("t7_addr_kept", err_addr, 32'h0400_0040);
    check("t7_code_kept", err_code, 2'b10);

    // Clear in the same cycle as a new error: new error is captured
    txn(32'h0700_0000, 32'h0, 4'h0, 1'b0, 1'b1);
    check("t8_addr", err_addr, 32'h0700_0000);
    check("t8_code", err_code, 2'b01);
    do_clr();
    check("t9_cnt_clr", txn_count, 64'd0);

    // Reset in the middle of an ACTIVE transfer
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0400_0100;
    bus.mem_wdata = 32'h0BAD_F00D;
    bus.mem_wstrb = 4'h0;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    e_saddr  = 32'h0400_0100;
    e_swdata = 32'h0BAD_F00D;
    e_swstrb = 4'h0;
    e_sv     = 4'b1000;
    @(posedge clk); #2;
    chk_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("rst_mid_s_valid",   bus.s_valid,   0);
    check("rst_mid_mem_ready", bus.mem_ready, 0);
    check("rst_mid_s_addr",    bus.s_addr,    0);
    e_sv = '0; e_saddr = '0; e_swdata = '0; e_swstrb = '0;
    e_eflag = 1'b0; e_ecode = '0; e_eaddr = '0;
    for (int i = 0; i < 4; i++) e_cnt[i] = '0;
    wait_cfg[3] = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    txn(32'h0200_0000, 32'h0, 4'h0, 1'b0, 1'b0);
    check("t10_latency", ready_cyc - acc_cyc + 1, 2);
    check("t10_rdata",   rd_obs, 32'hC0DE_0000);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/picosoc_bus_fabric.md
Name: picosoc_bus_fabric

Overview:
Parametrised successor to the SoC's fixed peripheral decode: a registered, N-slave address decoder/response mux on the picorv32 native memory bus. It replaces the hard-wired ready/rdata OR-chain between the CPU and peripherals (UART/SPI cfg, TCAM MMIO, action MMIO, external iomem), one slave per channel. It adds behaviour the fixed decode lacks: a bus timeout, error responses for unmapped addresses, and sticky error capture.

Parameters:
NUM_SLAVES, 4, number of slave channels (1..16)
SLAVE_BASE, {32'h0400_0000,32'h0301_0000,32'h0300_0000,32'h0200_0000}, packed NUM_SLAVES*32 base addresses; slice i is slave i
SLAVE_MASK, {32'hFF00_0000,32'hFFFF_0000,32'hFFFF_0000,32'hFFFF_FF00}, packed NUM_SLAVES*32 masks; slave i hits when (addr & MASK[i]) == BASE[i]
TIMEOUT_CYCLES, 255, maximum cycles in ACTIVE before forced error response; 0 disables the timeout
ERR_DATA, 32'hDEAD_BEEF, rdata returned on any error response
CNT_W, 16, width of per-slave transaction counters (optional feature)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  CPU request valid
mem_addr  in  32  CPU address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  CPU byte strobes; 0 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready
s_valid  out  NUM_SLAVES  one-hot slave request
s_addr  out  32  latched address, broadcast
s_wdata  out  32  latched write data, broadcast
s_wstrb  out  4  latched strobes, broadcast
s_ready  in  NUM_SLAVES  per-slave ready
s_rdata  in  NUM_SLAVES*32  per-slave read data
err_flag  out  1  sticky error
err_code  out  2  01 unmapped, 10 timeout, 00 none
err_addr  out  32  address of the first error since the last clear
err_clr  in  1  clears err_flag/err_code/err_addr
txn_count  out  NUM_SLAVES*CNT_W  per-slave completed-transaction counters (optional feature)

Behaviour:
- Reset: asynchronous and active-low. All outputs go to 0 and the FSM goes to IDLE, regardless of the current state (this includes aborting an ACTIVE transfer).
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, mem_valid=1: latch addr/wdata/wstrb into the s_* registers and decode.
  - Lowest matching index wins when windows overlap.
  - Hit: go to ACTIVE; s_valid[sel]=1 from the next cycle.
  - Miss: go to RESP with rdata=ERR_DATA and set error code 01.
- ACTIVE:
  - s_valid, s_addr, s_wdata and s_wstrb are held stable. A timeout counter starts at 0 and increments each cycle.
  - s_ready[sel]=1: capture s_rdata[sel], drop s_valid, go to RESP.
  - Counter == TIMEOUT_CYCLES-1 with no ready: drop s_valid, go to RESP with ERR_DATA and set error code 10.
  - s_ready on non-selected slaves is ignored.
- RESP: mem_ready=1 for exactly one cycle, with mem_rdata holding the captured value; go to IDLE. In every other state, mem_ready=0 and mem_rdata=0.
- Latency:
  - Hit with a zero-wait slave: mem_ready appears 2 cycles after mem_valid is sampled.
  - Unmapped address: mem_ready appears 1 cycle after mem_valid is sampled.
- Back-to-back: a new mem_valid in the cycle after RESP is accepted in IDLE; there is no dead cycle beyond RESP.
- mem_valid deasserting during ACTIVE is ignored; the transaction completes.
- Errors:
  - err_flag, err_code and err_addr capture the first error only; later errors do not overwrite them.
  - err_clr in the same cycle as a new error: the new error wins and is captured.
- Write errors (wstrb≠0) respond identically to read errors; nothing is written.

Optional Feature:
BUS_TXN_COUNT_EN
- Defined: txn_count slice i increments, wrapping, on each completed s_ready handshake from slave i. err_clr also zeroes all counters. Timeouts and unmapped accesses are not counted.
- Undefined: no counter flops; txn_count is tied to 0.

Decomposition:
- Package picosoc_bus_pkg: FSM state encoding, ERR_UNMAPPED=2'b01, ERR_TIMEOUT=2'b10, default ERR_DATA.
- Sub-module bus_addr_decode: combinational priority matcher from addr to {hit, sel index}, parametrised by NUM_SLAVES, SLAVE_BASE and SLAVE_MASK.

Test Plan:
- Read 0x0300_0010; slave1 gives ready the first ACTIVE cycle with rdata 0x1234_5678 → s_valid=4'b0010; mem_ready 2 cycles after valid with rdata 0x1234_5678; err_flag=0.
- Write 0x0301_0004, wdata 0xA5A5_0001, wstrb 4'hF; slave2 waits 5 cycles → s_* stable throughout; exactly one mem_ready pulse.
- Read 0x0500_0000 (unmapped) → mem_ready 1 cycle later with rdata 0xDEAD_BEEF; err_code=01; err_addr=0x0500_0000.
- Slave3 never readies, TIMEOUT_CYCLES=8 → s_valid drops after 8 ACTIVE cycles; mem_ready with 0xDEAD_BEEF; err_code=10. A following good access leaves the err fields unchanged.
- resetn low mid-ACTIVE → s_valid and mem_ready are 0 immediately; after release, a read of 0x0200_0000 completes normally.
- With BUS_TXN_COUNT_EN defined: 3 slave1 accesses and 1 timeout on slave3 → txn_count[1]=3, txn_count[3]=0; err_clr → all counters 0.
